// File: rtl/icache_direct_pkg.sv
// Shared types for the direct-mapped instruction cache: FSM states and fetch address fields.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package icache_direct_pkg;

  localparam int DEF_SETS   = 16;
  localparam int DEF_WORD_W = 32;
  localparam int DEF_IDX_W  = $clog2(DEF_SETS);
  localparam int DEF_TAG_W  = DEF_WORD_W - DEF_IDX_W - 2;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } icache_state_t;

  // Fetch address split for the default geometry: tag | index | byte offset.
  typedef struct packed {
    logic [DEF_TAG_W-1:0] tag;
    logic [DEF_IDX_W-1:0] idx;
    logic [1:0]           bytoff;
  } icachef_t;

endpackage

// File: rtl/icache_frames.sv
// Frame store (valid/tag/data) with one write port, a combinational read port and flush-all.
// Latency: read is combinational; writes and flush take effect on the next CLK edge.
// Backpressure: none; flush_i wins over wr_en_i, so a frame written during a flush ends invalid.
// Ports: rd_idx_i -> rd_vld_o/rd_tag_o/rd_dat_o; wr_en_i/wr_idx_i/wr_tag_i/wr_dat_i; flush_i.
module icache_frames
  import icache_direct_pkg::*;
#(
  parameter int SETS   = DEF_SETS,
  parameter int WORD_W = DEF_WORD_W,
  parameter int IDX_W  = $clog2(SETS),
  parameter int TAG_W  = WORD_W - IDX_W - 2
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic              rd_vld_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [WORD_W-1:0] rd_dat_o,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [WORD_W-1:0] wr_dat_i,
  input  logic              flush_i
);

  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q [SETS];
  logic [WORD_W-1:0] dat_q [SETS];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag/data are qualified by valid_q, so they carry no reset.
  always_ff @(posedge CLK) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i] <= wr_tag_i;
      dat_q[wr_idx_i] <= wr_dat_i;
    end
  end

  assign rd_vld_o = valid_q[rd_idx_i];
  assign rd_tag_o = tag_q[rd_idx_i];
  assign rd_dat_o = dat_q[rd_idx_i];

endmodule

// File: rtl/icache_direct.sv
// Per-core direct-mapped instruction cache, one-word blocks, single-word fills from the controller.
// Latency: hits are combinational; a miss costs 1 + controller latency + 1 cycles.
// Backpressure: iREN is held with a stable iaddr until iwait=0; stalls of any length are tolerated.
// Ports: CPU side imemREN/imemaddr/flush -> ihit/imemload; memory side iREN/iaddr <- iwait/iload.
module icache_direct
  import icache_direct_pkg::*;
#(
  parameter int SETS   = DEF_SETS,
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [WORD_W-1:0] imemaddr,
  input  logic              flush,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic              iwait,
  input  logic [WORD_W-1:0] iload
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = WORD_W - IDX_W - 2;

  icache_state_t     state_q, state_d;
  logic [WORD_W-1:0] miss_addr_q, miss_addr_d;
  logic              flush_pend_q, flush_pend_d;
  logic [31:0]       hit_cnt_q, miss_cnt_q;

  logic              hit, miss_start, fill_we, flush_all;
  logic              rd_vld;
  logic [TAG_W-1:0]  rd_tag;
  logic [WORD_W-1:0] rd_dat;

  logic [IDX_W-1:0]  req_idx, fill_idx;
  logic [TAG_W-1:0]  req_tag, fill_tag;

  assign req_idx  = imemaddr[IDX_W+1:2];
  assign req_tag  = imemaddr[WORD_W-1:IDX_W+2];
  assign fill_idx = miss_addr_q[IDX_W+1:2];
  assign fill_tag = miss_addr_q[WORD_W-1:IDX_W+2];

  icache_frames #(
    .SETS   (SETS),
    .WORD_W (WORD_W),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W)
  ) u_frames (
    .CLK      (CLK),
    .nRST     (nRST),
    .rd_idx_i (req_idx),
    .rd_vld_o (rd_vld),
    .rd_tag_o (rd_tag),
    .rd_dat_o (rd_dat),
    .wr_en_i  (fill_we),
    .wr_idx_i (fill_idx),
    .wr_tag_i (fill_tag),
    .wr_dat_i (iload),
    .flush_i  (flush_all)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      miss_addr_q  <= '0;
      flush_pend_q <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      miss_addr_q  <= miss_addr_d;
      flush_pend_q <= flush_pend_d;
      if (hit)        hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_start) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  always_comb begin
    state_d      = state_q;
    miss_addr_d  = miss_addr_q;
    flush_pend_d = flush_pend_q;
    hit          = 1'b0;
    miss_start   = 1'b0;
    fill_we      = 1'b0;
    flush_all    = 1'b0;
    iREN         = 1'b0;
    iaddr        = '0;
    unique case (state_q)
      IDLE: begin
        // A flush in the same cycle suppresses the hit: the frame is being invalidated.
        hit       = imemREN && rd_vld && (rd_tag == req_tag) && !flush;
        flush_all = flush;
        if (imemREN && !hit) begin
          miss_addr_d = imemaddr;
          miss_start  = 1'b1;
          state_d     = MISS;
        end
      end
      MISS: begin
        iREN  = 1'b1;
        iaddr = miss_addr_q;
        if (flush) flush_pend_d = 1'b1;
        if (!iwait) begin
          // The fill is written regardless; a pending or coincident flush
          // clears every valid bit on the same edge, fill frame included.
          fill_we      = 1'b1;
          flush_all    = flush_pend_q || flush;
          flush_pend_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ihit     = hit;
    imemload = hit ? rd_dat : '0;
  end

  // Byte offsets and the probe-only counters have no consumer inside the block.
  logic unused_ok;
  assign unused_ok = ^{imemaddr[1:0], miss_addr_q[1:0], hit_cnt_q, miss_cnt_q};

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: hit/miss/fill, conflicts, stalls, flush and reset.
// Latency: expected fetch words are queued when a hit is due and popped when ihit is observed.
// Backpressure: the bench plays the memory controller, stalling fills with iwait for set counts.
module tb_icache_direct;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        flush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  int          checks;
  int          failures;
  int          exp_hits;
  int          exp_misses;
  logic [31:0] sb_q [$];

  icache_direct #(.SETS(16), .WORD_W(32)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .flush    (flush),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Controller memory contents.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h8C22_0004;
    return 32'hA5A5_0000 ^ a;
  endfunction

  task automatic req(input logic [31:0] a);
    @(negedge CLK);
    imemREN  = 1'b1;
    imemaddr = a;
    #1;
  endtask

  task automatic idle();
    @(negedge CLK);
    imemREN = 1'b0;
    #1;
  endtask

  task automatic expect_hit(input string tg, input logic [31:0] a);
    logic [31:0] exp;
    sb_q.push_back(mem_word(a));
    exp_hits++;
    chk({tg, "_ihit"}, {31'b0, ihit}, 32'd1);
    chk({tg, "_iren"}, {31'b0, iREN}, 32'd0);
    if (ihit) begin
      if (sb_q.size() == 0) begin
        chk({tg, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
        exp = sb_q.pop_front();
        chk({tg, "_load"}, imemload, exp);
      end
    end else begin
      void'(sb_q.pop_front());
    end
  endtask

  // Called in the IDLE decision cycle of a miss. fl_mode: 0 none, 1 flush
  // in the first MISS cycle, 2 flush on the fill-completion cycle.
  task automatic expect_miss_fill(input string tg, input logic [31:0] a, input int stall,
                                  input logic [31:0] move_to, input int fl_mode);
    chk({tg, "_dec_ihit"}, {31'b0, ihit}, 32'd0);
    chk({tg, "_dec_load"}, imemload, 32'd0);
    exp_misses++;
    @(negedge CLK);
    imemaddr = move_to;
    flush    = (fl_mode == 1);
    #1;
    chk({tg, "_miss_iren"}, {31'b0, iREN}, 32'd1);
    chk({tg, "_miss_iaddr"}, iaddr, a);
    chk({tg, "_miss_ihit"}, {31'b0, ihit}, 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(negedge CLK);
      flush = 1'b0;
      #1;
      chk({tg, "_stall_iaddr"}, iaddr, a);
      chk({tg, "_stall_iren"}, {31'b0, iREN}, 32'd1);
    end
    @(negedge CLK);
    flush = (fl_mode == 2);
    iwait = 1'b0;
    iload = mem_word(a);
    #1;
    chk({tg, "_done_iren"}, {31'b0, iREN}, 32'd1);
    chk({tg, "_done_iaddr"}, iaddr, a);
    @(negedge CLK);
    flush = 1'b0;
    iwait = 1'b1;
    iload = 32'd0;
    #1;
    chk({tg, "_post_iren"}, {31'b0, iREN}, 32'd0);
  endtask

  task automatic chk_counters(input string tg);
    chk({tg, "_hit_cnt"}, dut.hit_cnt_q, 32'(exp_hits));
    chk({tg, "_miss_cnt"}, dut.miss_cnt_q, 32'(exp_misses));
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    exp_hits   = 0;
    exp_misses = 0;
    nRST       = 1'b0;
    imemREN    = 1'b0;
    imemaddr   = 32'd0;
    flush      = 1'b0;
    iwait      = 1'b1;
    iload      = 32'd0;

    #1;
    chk("rst_ihit", {31'b0, ihit}, 32'd0);
    chk("rst_load", imemload, 32'd0);
    chk("rst_iren", {31'b0, iREN}, 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    chk("rst_state", {31'b0, dut.state_q}, 32'd0);
    chk("rst_fpend", {31'b0, dut.flush_pend_q}, 32'd0);
    chk_counters("rst");
    @(negedge CLK);
    nRST = 1'b1;

    // Cold fetch then repeat hit.
    req(32'h40);
    expect_miss_fill("cold", 32'h40, 2, 32'h40, 0);
    expect_hit("cold_fill", 32'h40);
    idle();
    req(32'h40);
    expect_hit("rep", 32'h40);
    idle();
    chk_counters("rep");

    // Conflict on index 0 evicts 0x40.
    req(32'h440);
    expect_miss_fill("conf", 32'h440, 1, 32'h440, 0);
    expect_hit("conf_fill", 32'h440);
    idle();
    req(32'h40);
    expect_miss_fill("evict", 32'h40, 0, 32'h40, 0);
    expect_hit("evict_fill", 32'h40);
    idle();

    // Address moves mid-MISS under a long stall; fill still targets 0x80.
    req(32'h80);
    expect_miss_fill("move", 32'h80, 10, 32'h84, 0);
    expect_miss_fill("move84", 32'h84, 0, 32'h84, 0);
    expect_hit("move84_fill", 32'h84);
    idle();
    req(32'h80);
    expect_hit("move80_later", 32'h80);
    idle();
    chk_counters("move");

    // Flush during MISS: all frames end invalid, including the fill.
    req(32'hC0);
    expect_miss_fill("fl_miss", 32'hC0, 3, 32'hC0, 1);
    expect_miss_fill("fl_refetch", 32'hC0, 0, 32'hC0, 0);
    expect_hit("fl_refetch_fill", 32'hC0);
    idle();
    req(32'h80);
    expect_miss_fill("fl_all", 32'h80, 0, 32'h80, 0);
    expect_hit("fl_all_fill", 32'h80);
    idle();

    // Flush coincident with fill completion.
    req(32'h100);
    expect_miss_fill("fl_end", 32'h100, 1, 32'h100, 2);
    expect_miss_fill("fl_end_re", 32'h100, 0, 32'h100, 0);
    expect_hit("fl_end_fill", 32'h100);
    idle();

    // Flush in IDLE masks what would otherwise be a hit.
    @(negedge CLK);
    imemREN  = 1'b1;
    imemaddr = 32'h100;
    flush    = 1'b1;
    #1;
    expect_miss_fill("fl_idle", 32'h100, 0, 32'h100, 0);
    expect_hit("fl_idle_fill", 32'h100);
    idle();
    chk_counters("flush");

    // Reset while a fill is outstanding.
    req(32'h200);
    chk("mrst_dec_ihit", {31'b0, ihit}, 32'd0);
    @(negedge CLK);
    #1;
    chk("mrst_iren_before", {31'b0, iREN}, 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    chk("mrst_iren", {31'b0, iREN}, 32'd0);
    chk("mrst_ihit", {31'b0, ihit}, 32'd0);
    chk("mrst_iaddr", iaddr, 32'd0);
    exp_hits   = 0;
    exp_misses = 0;
    chk_counters("mrst");
    @(negedge CLK);
    nRST     = 1'b1;
    imemaddr = 32'h40;
    #1;
    expect_miss_fill("post_rst", 32'h40, 1, 32'h40, 0);
    expect_hit("post_rst_fill", 32'h40);
    idle();
    chk_counters("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
